ebi_master: RTL
===============

Name: ebi_master

Overview:
- Bus initiator for the multiplexed 16-bit EBI used to load the display memories: OAM, sprite VRAM, tile VRAM, palette and TAM.
- Takes one request at a time over a valid/ready handshake and generates address-latch, strobe and hold phases on EBI_AD/EBI_ALE/EBI_WE/EBI_RE/bank_select.
- Used as the FPGA-side initiator in the bring-up/loader path and as the bus-functional driver for display-driver integration benches.
- Supports writes and single-word reads. For reads it samples EBI_AD_i and returns the data on a response strobe.

Parameters:
- ALE_CYCLES, 2, cycles EBI_ALE is held high with the address on EBI_AD (≥1).
- STROBE_CYCLES, 2, cycles EBI_WE or EBI_RE is held low (≥1).
- HOLD_CYCLES, 1, cycles after the strobe rises before the bus is released (≥1).
- CNT_W, 4, phase counter width; must hold max(ALE_CYCLES, STROBE_CYCLES, HOLD_CYCLES).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a clk edge.
- req_write  in  1  1 = write, 0 = read.
- req_bank  in  3  target bank: 0 OAM, 1 sprite VRAM, 2 tile VRAM, 3 palette, 4 TAM.
- req_addr  in  16  word address.
- req_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle pulse with read data.
- rsp_rdata  out  16  read data; stable until the next read completes.
- busy  out  1  high whenever state != IDLE.
- EBI_AD_o  out  16  address/data out.
- EBI_AD_oe  out  1  AD output enable.
- EBI_AD_i  in  16  AD input, used on reads.
- EBI_ALE  out  1  address latch enable, active-high.
- EBI_WE  out  1  write strobe, active-low.
- EBI_RE  out  1  read strobe, active-low.
- bank_select  out  3  bank of the current transaction.

Behaviour:
- All outputs are registered. Exception: req_ready = (state == IDLE) && !reset.
- Reset values: EBI_ALE 0, EBI_WE 1, EBI_RE 1, EBI_AD_oe 0, EBI_AD_o 0, bank_select 0, rsp_valid 0, rsp_rdata 0, busy 0, state IDLE, counter 0.
- Reset asserted mid-transaction forces all outputs to reset values immediately (asynchronously). The aborted request produces no response.
- On accept, the request is captured into internal registers. Input changes afterwards have no effect.
- States and transitions:
  - IDLE: on accept → ADDR.
  - ADDR: AD_o = addr, AD_oe 1, ALE 1, bank_select = bank. Lasts ALE_CYCLES, then → ADDR_HOLD.
  - ADDR_HOLD: ALE 0, address still driven. Lasts 1 cycle, then → STROBE.
  - STROBE:
    - Write: AD_o = wdata, AD_oe 1, WE 0.
    - Read: AD_oe 0, RE 0.
    - Lasts STROBE_CYCLES, then → HOLD.
  - HOLD: WE/RE 1. Write keeps data driven; read keeps AD_oe 0. Lasts HOLD_CYCLES, then → IDLE with AD_oe 0.
- Read sampling: EBI_AD_i is sampled at the clock edge that ends the last STROBE cycle. rsp_rdata updates at that edge. rsp_valid is high for exactly the first HOLD cycle.
- Writes never assert rsp_valid.
- Timing with defaults: accept at edge 0 → ADDR in cycles 1–2, ADDR_HOLD in 3, STROBE in 4–5, HOLD in 6, IDLE (req_ready 1) in 7. Maximum throughput is one transaction per 7 cycles.
- bank_select holds its value in IDLE between transactions. It changes only on entry to ADDR.
- ALE and a strobe are never low/high together: ALE=1 implies WE=RE=1. WE and RE are never both low.
- AD_oe is never 1 while RE is 0.
- The phase counter loads N-1 on phase entry and decrements. The phase ends when the counter reaches 0; no wrap is used.

Decomposition:
- Package ebi_pkg, containing:
  - EBI_AD_W = 16 and BANK_W = 3.
  - Enum bank_e: BANK_OAM=0, BANK_SPRITE=1, BANK_TILE=2, BANK_PALETTE=3, BANK_TAM=4.
  - Enum ebi_state_e: IDLE, ADDR, ADDR_HOLD, STROBE, HOLD.
  - Packed struct ebi_req_t {write, bank, addr, wdata}.
- No sub-module. The FSM and the phase counter live in one module.

Test Plan:
- Reset values: reset high → all outputs at reset values, req_ready 0. Release reset → req_ready 1 on the next cycle.
- Single palette write: bank 3, addr 0x0012, data 0x0F0A → ALE high in cycles 1–2 with AD=0x0012 and bank_select=3. WE low in cycles 4–5 with AD=0x0F0A. req_ready returns in cycle 7. rsp_valid stays 0.
- Single OAM read, bench drives EBI_AD_i=0xBEEF during RE low: addr 0x0005 → AD_oe 0 in cycles 4–6, RE low in cycles 4–5. rsp_valid pulses in cycle 6 with rsp_rdata=0xBEEF.
- Back-to-back: three writes with req_valid held high → accepts at cycles 0, 7 and 14. Protocol invariants hold throughout, checked by assertions.
- Reset mid-transaction: assert reset in cycle 4 of a write → WE=1, AD_oe=0, ALE=0 in the same cycle. After release, the state is IDLE and no response is produced.
- Parameter sweep ALE=1, STROBE=3, HOLD=2 → a write accepted at cycle 0 completes with req_ready high in cycle 8.

Source files
------------

// File: rtl/ebi_pkg.sv
// Shared types for the multiplexed 16-bit EBI initiator used to load the display memories.
package ebi_pkg;

  localparam int EBI_AD_W = 16;
  localparam int BANK_W   = 3;

  typedef enum logic [BANK_W-1:0] {
    BANK_OAM     = 3'd0,
    BANK_SPRITE  = 3'd1,
    BANK_TILE    = 3'd2,
    BANK_PALETTE = 3'd3,
    BANK_TAM     = 3'd4
  } bank_e;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_HOLD,
    STROBE,
    HOLD
  } ebi_state_e;

  typedef struct packed {
    logic                write;
    logic [BANK_W-1:0]   bank;
    logic [EBI_AD_W-1:0] addr;
    logic [EBI_AD_W-1:0] wdata;
  } ebi_req_t;

endpackage

// File: rtl/ebi_master.sv
// EBI bus initiator: one request at a time, sequenced through address-latch,
// strobe and hold phases; single-word reads return data on a response pulse.
module ebi_master
  import ebi_pkg::*;
#(
  parameter int ALE_CYCLES    = 2,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int CNT_W         = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [BANK_W-1:0]   req_bank,
  input  logic [EBI_AD_W-1:0] req_addr,
  input  logic [EBI_AD_W-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [EBI_AD_W-1:0] rsp_rdata,
  output logic                busy,
  output logic [EBI_AD_W-1:0] EBI_AD_o,
  output logic                EBI_AD_oe,
  input  logic [EBI_AD_W-1:0] EBI_AD_i,
  output logic                EBI_ALE,
  output logic                EBI_WE,
  output logic                EBI_RE,
  output logic [BANK_W-1:0]   bank_select
);

  localparam logic [CNT_W-1:0] ALE_LD    = CNT_W'(ALE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

  ebi_state_e          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  ebi_req_t            req_q, req_cur;
  logic                accept;
  logic                sample;
  logic                ale_nxt, we_nxt, re_nxt, oe_nxt;
  logic [EBI_AD_W-1:0] ad_nxt;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      req_q <= req_cur;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_cur   = req_q;
    if (accept) begin
      req_cur = '{write: req_write, bank: req_bank, addr: req_addr, wdata: req_wdata};
    end

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ADDR;
          cnt_nxt   = ALE_LD;
        end
      end
      ADDR: begin
        if (cnt == '0) begin
          state_nxt = ADDR_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ADDR_HOLD: begin
        state_nxt = STROBE;
        cnt_nxt   = STROBE_LD;
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Read data is captured on the edge that closes the last strobe cycle.
    sample = (state == STROBE) && (cnt == '0) && !req_q.write;

    // Bus outputs are a registered decode of the state being entered.
    ale_nxt = (state_nxt == ADDR);
    we_nxt  = !((state_nxt == STROBE) && req_cur.write);
    re_nxt  = !((state_nxt == STROBE) && !req_cur.write);
    oe_nxt  = 1'b0;
    ad_nxt  = EBI_AD_o;
    case (state_nxt)
      ADDR, ADDR_HOLD: begin
        oe_nxt = 1'b1;
        ad_nxt = req_cur.addr;
      end
      STROBE, HOLD: begin
        if (req_cur.write) begin
          oe_nxt = 1'b1;
          ad_nxt = req_cur.wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      EBI_ALE     <= 1'b0;
      EBI_WE      <= 1'b1;
      EBI_RE      <= 1'b1;
      EBI_AD_oe   <= 1'b0;
      EBI_AD_o    <= '0;
      bank_select <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      busy        <= 1'b0;
    end else begin
      EBI_ALE   <= ale_nxt;
      EBI_WE    <= we_nxt;
      EBI_RE    <= re_nxt;
      EBI_AD_oe <= oe_nxt;
      EBI_AD_o  <= ad_nxt;
      busy      <= (state_nxt != IDLE);
      rsp_valid <= sample;
      if (sample) rsp_rdata <= EBI_AD_i;
      if (accept) bank_select <= req_cur.bank;
    end
  end

endmodule
